txn_mem_responder: RTL

Synthesizable responder for the fabric transaction port (`txn_req`/`txn_wr`/`txn_addr`/`txn_wdata`/`txn_rdata`/`txn_rdy`). It holds two on-chip word banks: a read bank that holds the cost map the fabric loads, and a write bank that receives the paths the fabric stores. Each access completes after a programmable latency. A host side port preloads the read bank and drains the write bank. The block sits between `fabric` and the SoC host, and replaces off-chip memory in FPGA builds.

---
 rtl/txn_pkg.sv | 14 +
 rtl/txn_mem_responder_if.sv | 21 ++
 rtl/txn_bank_ram.sv | 34 +++
 rtl/txn_mem_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/txn_pkg.sv
// rtl/txn_pkg.sv - shared types and constants for the transaction memory responder
package txn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] TXN_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] RD_BASE_DEF  = 32'h4000_0000;
  localparam logic [31:0] WR_BASE_DEF  = 32'h4000_1000;

endpackage

// File: rtl/txn_mem_responder_if.sv
// rtl/txn_mem_responder_if.sv - fabric transaction port bundle
interface txn_mem_responder_if;

  logic        txn_req;
  logic        txn_wr;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;
  logic [31:0] txn_rdata;
  logic        txn_rdy;

  modport master (
    output txn_req, txn_wr, txn_addr, txn_wdata,
    input  txn_rdata, txn_rdy
  );

  modport slave (
    input  txn_req, txn_wr, txn_addr, txn_wdata,
    output txn_rdata, txn_rdy
  );

endinterface

// File: rtl/txn_bank_ram.sv
// rtl/txn_bank_ram.sv - word bank with prioritised dual write and txn/host read ports
module txn_bank_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [31:0]   wdata_a,
  output logic [31:0]   rdata_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [31:0]   wdata_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem [DEPTH];

  // Port B is written first so a same-word port A write lands last and wins
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wdata_b;
    if (we_a) mem[addr_a] <= wdata_a;
  end

  // Registered host-side read; contents are never reset, only the output register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) rdata_b <= '0;
    else      rdata_b <= mem[addr_b];
  end

  assign rdata_a = mem[addr_a];

endmodule

// File: rtl/txn_mem_responder.sv
// rtl/txn_mem_responder.sv - fixed-latency fabric memory responder with host preload/drain port
module txn_mem_responder
  import txn_pkg::*;
#(
  parameter int          DEPTH   = 128,
  parameter int          LATENCY = 16,
  parameter logic [31:0] RD_BASE = RD_BASE_DEF,
  parameter logic [31:0] WR_BASE = WR_BASE_DEF
) (
  input  logic                     clk,
  input  logic                     arst,
  txn_mem_responder_if.slave       bus,
  input  logic                     host_we,
  input  logic                     host_bank,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [31:0]              host_wdata,
  output logic [31:0]              host_rdata,
  output logic                     txn_err,
  input  logic                     err_clr
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  state_t        state, state_n;
  logic [4:0]    cnt, cnt_n;
  logic          rdy, rdy_n;
  logic          accept, complete;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic          lat_ok;
  logic          host_bank_q;

  logic [31:0]   off_rd, off_wr;
  logic          req_ok;
  logic [AW-1:0] req_idx;
  logic [31:0]   rd_rdata_a, rd_rdata_b, wr_rdata_b;
  logic          txn_we;

  // Offsets wrap for addresses below a base, which then fail the span check
  always_comb begin
    off_rd  = bus.txn_addr - RD_BASE;
    off_wr  = bus.txn_addr - WR_BASE;
    req_ok  = bus.txn_wr ? (off_wr < SPAN) : (off_rd < SPAN);
    req_idx = bus.txn_wr ? off_wr[AW+1:2] : off_rd[AW+1:2];
  end

  // Next-state logic: accept in IDLE, count down the latency, then complete
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rdy_n    = rdy;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (bus.txn_req) begin
          accept  = 1'b1;
          cnt_n   = 5'(LATENCY);
          rdy_n   = 1'b0;
          state_n = bus.txn_wr ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt != 5'd0) begin
          cnt_n = cnt - 5'd1;
        end else begin
          complete = 1'b1;
          rdy_n    = 1'b1;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
      end
    endcase
  end

  // State register; reset abandons any access in flight and raises rdy at once
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      rdy   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rdy   <= rdy_n;
    end
  end

  // Request capture, read data return, sticky error and host bank select
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lat_idx     <= '0;
      lat_wdata   <= '0;
      lat_ok      <= 1'b0;
      bus.txn_rdata <= '0;
      txn_err     <= 1'b0;
      host_bank_q <= 1'b0;
    end else begin
      host_bank_q <= host_bank;
      if (accept) begin
        lat_idx   <= req_idx;
        lat_wdata <= bus.txn_wdata;
        lat_ok    <= req_ok;
      end
      if (complete && state == RD_WAIT) begin
        bus.txn_rdata <= lat_ok ? rd_rdata_a : TXN_ERR_DATA;
      end
      if (complete && !lat_ok) txn_err <= 1'b1;
      else if (err_clr)        txn_err <= 1'b0;
    end
  end

  assign txn_we      = complete && (state == WR_WAIT) && lat_ok;
  assign bus.txn_rdy = rdy;
  assign host_rdata  = host_bank_q ? wr_rdata_b : rd_rdata_b;

  txn_bank_ram #(.DEPTH(DEPTH)) u_rd_bank (
    .clk     (clk),
    .arst    (arst),
    .we_a    (1'b0),
    .addr_a  (lat_idx),
    .wdata_a (32'h0),
    .rdata_a (rd_rdata_a),
    .we_b    (host_we && !host_bank),
    .addr_b  (host_addr),
    .wdata_b (host_wdata),
    .rdata_b (rd_rdata_b)
  );

  txn_bank_ram #(.DEPTH(DEPTH)) u_wr_bank (
    .clk     (clk),
    .arst    (arst),
    .we_a    (txn_we),
    .addr_a  (lat_idx),
    .wdata_a (lat_wdata),
    .rdata_a (),
    .we_b    (host_we && host_bank),
    .addr_b  (host_addr),
    .wdata_b (host_wdata),
    .rdata_b (wr_rdata_b)
  );

endmodule
